// File: rtl/obstacle_pool.sv
// Obstacle pool: a fixed set of obstacle slots that scroll left on each game tick.
// Slots retire off the left edge, and new obstacles spawn at SPAWN_X subject to a
// random threshold and a minimum spacing behind the most recently spawned obstacle.
// Optional feature: define OBSTACLE_POOL_SPEED_RAMP_EN to add a speed ramp that
// grows by one every 16 spawns (saturating at 3). The step is then capped at 4.
module obstacle_pool #(
  parameter int NUM_OBS      = 4,
  parameter int CONV         = 2,
  parameter int SPAWN_X      = 159,
  parameter int MIN_GAP      = 40,
  parameter int SPAWN_THRESH = 8,
  localparam int PW          = 10 - CONV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  game_tick,
  input  logic                  game_start,
  input  logic                  game_frozen,
  input  logic [7:0]            rng,
  input  logic [1:0]            speed,
  output logic [NUM_OBS*PW-1:0] obs_pos,
  output logic [NUM_OBS*3-1:0]  obs_type,
  output logic [NUM_OBS-1:0]    obs_active,
  output logic                  spawn_pulse,
  output logic                  passed_pulse
);

  localparam int IW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
  localparam logic [PW-1:0] SpawnPos = PW'(SPAWN_X);
  // The last spawn must have moved at least this far left before another spawn.
  localparam logic [PW-1:0] GapPos   = PW'(SPAWN_X - MIN_GAP);
  localparam logic [4:0]    Thresh   = 5'(SPAWN_THRESH);

  logic [PW-1:0]      pos_q  [NUM_OBS];
  logic [PW-1:0]      pos_d  [NUM_OBS];
  logic [2:0]         type_q [NUM_OBS];
  logic [2:0]         type_d [NUM_OBS];
  logic [NUM_OBS-1:0] active_q, active_d;
  logic [IW-1:0]      last_q, last_d;
  logic               last_vld_q, last_vld_d;
  logic               spawn_q, spawn_d;
  logic               passed_q, passed_d;

  logic [2:0]         step;
  logic [PW-1:0]      step_ext;
  logic               free_found;
  logic [IW-1:0]      free_idx;
  logic               gap_ok;
  logic [2:0]         new_type;

`ifdef OBSTACLE_POOL_SPEED_RAMP_EN
  logic [1:0] ramp_q, ramp_d;
  logic [3:0] spawn_cnt_q, spawn_cnt_d;
  logic [2:0] step_sum;

  // Ramped step, capped at 4 pixels per tick.
  always_comb begin
    step_sum = 3'({1'b0, speed}) + 3'd1 + 3'({1'b0, ramp_q});
    step     = (step_sum > 3'd4) ? 3'd4 : step_sum;
  end
`else
  // Base step only.
  always_comb begin
    step = 3'({1'b0, speed}) + 3'd1;
  end
`endif

  assign step_ext = PW'(step);
  // Types 6 and 7 fold back onto 0 and 1.
  assign new_type = (rng[2:0] <= 3'd5) ? rng[2:0] : rng[2:0] - 3'd6;

  // Next-state: move/retire active slots, then decide on a spawn into a pre-tick free slot.
  always_comb begin
    pos_d      = pos_q;
    type_d     = type_q;
    active_d   = active_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    spawn_d    = 1'b0;
    passed_d   = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    gap_ok     = 1'b0;
`ifdef OBSTACLE_POOL_SPEED_RAMP_EN
    ramp_d      = ramp_q;
    spawn_cnt_d = spawn_cnt_q;
`endif
    if (game_tick && !game_frozen) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        if (active_q[i]) begin
          if (pos_q[i] < step_ext) begin
            active_d[i] = 1'b0;
            pos_d[i]    = SpawnPos;
            type_d[i]   = 3'd0;
            passed_d    = 1'b1;
          end else begin
            pos_d[i] = pos_q[i] - step_ext;
          end
        end
      end
      // Descending scan so the lowest free index wins; uses pre-tick occupancy so a
      // slot retired this tick is not reused until the next one.
      for (int i = NUM_OBS - 1; i >= 0; i--) begin
        if (!active_q[i]) begin
          free_found = 1'b1;
          free_idx   = IW'(i);
        end
      end
      gap_ok = !last_vld_q || !active_d[last_q] || (pos_d[last_q] <= GapPos);
      if (free_found && (rng[7:3] < Thresh) && gap_ok) begin
        active_d[free_idx] = 1'b1;
        pos_d[free_idx]    = SpawnPos;
        type_d[free_idx]   = new_type;
        last_d             = free_idx;
        last_vld_d         = 1'b1;
        spawn_d            = 1'b1;
`ifdef OBSTACLE_POOL_SPEED_RAMP_EN
        spawn_cnt_d = spawn_cnt_q + 4'd1;
        if (spawn_cnt_q == 4'd15 && ramp_q != 2'd3) begin
          ramp_d = ramp_q + 2'd1;
        end
`endif
      end
    end
  end

  // State register; reset and new-game both return the pool to empty.
  always_ff @(posedge clk) begin
    if (rst || game_start) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        pos_q[i]  <= SpawnPos;
        type_q[i] <= 3'd0;
      end
      active_q   <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      spawn_q    <= 1'b0;
      passed_q   <= 1'b0;
`ifdef OBSTACLE_POOL_SPEED_RAMP_EN
      ramp_q      <= 2'd0;
      spawn_cnt_q <= 4'd0;
`endif
    end else begin
      pos_q      <= pos_d;
      type_q     <= type_d;
      active_q   <= active_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      spawn_q    <= spawn_d;
      passed_q   <= passed_d;
`ifdef OBSTACLE_POOL_SPEED_RAMP_EN
      ramp_q      <= ramp_d;
      spawn_cnt_q <= spawn_cnt_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_pack
    assign obs_pos[g*PW +: PW] = pos_q[g];
    assign obs_type[g*3 +: 3]  = type_q[g];
  end

  assign obs_active   = active_q;
  assign spawn_pulse  = spawn_q;
  assign passed_pulse = passed_q;

endmodule

// File: tb/tb_obstacle_pool.sv
// Self-checking bench for obstacle_pool: directed scenarios plus randomized traffic,
// all compared every cycle against an array-based reference model of the pool rules.
module tb_obstacle_pool;

  localparam int NUM_OBS = 4;
  localparam int PW      = 8;
  localparam int SPAWN_X = 159;
  localparam int MIN_GAP = 40;
  localparam int THRESH  = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  game_tick;
  logic                  game_start;
  logic                  game_frozen;
  logic [7:0]            rng;
  logic [1:0]            speed;
  logic [NUM_OBS*PW-1:0] obs_pos;
  logic [NUM_OBS*3-1:0]  obs_type;
  logic [NUM_OBS-1:0]    obs_active;
  logic                  spawn_pulse;
  logic                  passed_pulse;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_pos  [NUM_OBS];
  int m_type [NUM_OBS];
  bit m_act  [NUM_OBS];
  int m_last;
  bit m_spawn;
  bit m_passed;

  always #5 clk = ~clk;

  obstacle_pool #(
    .NUM_OBS     (NUM_OBS),
    .CONV        (2),
    .SPAWN_X     (SPAWN_X),
    .MIN_GAP     (MIN_GAP),
    .SPAWN_THRESH(THRESH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .game_tick   (game_tick),
    .game_start  (game_start),
    .game_frozen (game_frozen),
    .rng         (rng),
    .speed       (speed),
    .obs_pos     (obs_pos),
    .obs_type    (obs_type),
    .obs_active  (obs_active),
    .spawn_pulse (spawn_pulse),
    .passed_pulse(passed_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_OBS; i++) begin
      m_pos[i]  = SPAWN_X;
      m_type[i] = 0;
      m_act[i]  = 0;
    end
    m_last   = -1;
    m_spawn  = 0;
    m_passed = 0;
  endtask

  // One effective game tick, straight from the movement/retire/spawn rules.
  task automatic model_tick(input int r, input int spd);
    int step;
    int free[$];
    bit gap;
    int s;
    int t;
    step     = spd + 1;
    m_spawn  = 0;
    m_passed = 0;
    for (int i = 0; i < NUM_OBS; i++) if (!m_act[i]) free.push_back(i);
    for (int i = 0; i < NUM_OBS; i++) begin
      if (m_act[i]) begin
        if (m_pos[i] < step) begin
          m_act[i]  = 0;
          m_pos[i]  = SPAWN_X;
          m_type[i] = 0;
          m_passed  = 1;
        end else begin
          m_pos[i] = m_pos[i] - step;
        end
      end
    end
    gap = (m_last < 0) || !m_act[m_last] || (m_pos[m_last] <= SPAWN_X - MIN_GAP);
    if (free.size() > 0 && (r >> 3) < THRESH && gap) begin
      s         = free[0];
      t         = r % 8;
      m_act[s]  = 1;
      m_pos[s]  = SPAWN_X;
      m_type[s] = (t <= 5) ? t : t - 6;
      m_last    = s;
      m_spawn   = 1;
    end
  endtask

  task automatic compare_all();
    logic [NUM_OBS-1:0] exp_act;
    for (int i = 0; i < NUM_OBS; i++) begin
      exp_act[i] = m_act[i];
      check($sformatf("pos%0d", i), 32'(obs_pos[i*PW +: PW]), m_pos[i]);
      check($sformatf("type%0d", i), 32'(obs_type[i*3 +: 3]), m_type[i]);
    end
    check("active", 32'(obs_active), 32'(exp_act));
    check("spawn_pulse", 32'(spawn_pulse), 32'(m_spawn));
    check("passed_pulse", 32'(passed_pulse), 32'(m_passed));
  endtask

  // Drive one cycle of inputs, advance the model on the same edge, compare just after.
  task automatic cycle(input bit r, input bit st, input bit tk, input bit fz,
                       input int rv, input int sp);
    rst         = r;
    game_start  = st;
    game_tick   = tk;
    game_frozen = fz;
    rng         = 8'(rv);
    speed       = 2'(sp);
    @(posedge clk);
    if (r || st) model_clear();
    else if (tk && !fz) model_tick(rv, sp);
    else begin
      m_spawn  = 0;
      m_passed = 0;
    end
    #1;
    compare_all();
  endtask

  initial begin
    int guard;
    model_clear();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("reset_active", 32'(obs_active), 0);
    check("reset_pos0", 32'(obs_pos[7:0]), SPAWN_X);

    // First spawn, then gap blocks the next one.
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 8'h00, 0);
    check("first_pos0", 32'(obs_pos[7:0]), 159);
    check("first_type0", 32'(obs_type[2:0]), 0);
    check("first_spawn", 32'(spawn_pulse), 1);
    cycle(0, 0, 0, 0, 8'h00, 0);
    check("spawn_one_cycle", 32'(spawn_pulse), 0);
    cycle(0, 0, 1, 0, 8'h00, 0);
    check("move_pos0", 32'(obs_pos[7:0]), 158);
    check("gap_no_spawn", 32'(spawn_pulse), 0);

    // Speed 3: second spawn lands exactly when slot0 reaches SPAWN_X-MIN_GAP.
    cycle(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) cycle(0, 0, 1, 0, 8'h00, 3);
    check("s3_pos0_t10", 32'(obs_pos[7:0]), 123);
    check("s3_slot1_idle", 32'(obs_active[1]), 0);
    cycle(0, 0, 1, 0, 8'h00, 3);
    check("s3_pos0_t11", 32'(obs_pos[7:0]), 119);
    check("s3_slot1_spawn", 32'(obs_active[1]), 1);
    check("s3_pos1", 32'(obs_pos[15:8]), 159);

    // Frozen with two active slots: nothing moves; start during a tick clears.
    for (int k = 0; k < 20; k++) cycle(0, 0, 1, 1, $urandom, $urandom);
    check("frozen_active", 32'(obs_active), 32'h3);
    check("frozen_pos0", 32'(obs_pos[7:0]), 119);
    cycle(0, 1, 1, 0, 8'h00, 3);
    check("start_clears", 32'(obs_active), 0);

    // High rng never spawns.
    for (int k = 0; k < 20; k++) cycle(0, 0, 1, 0, 8'hFF, 1);
    check("rng_ff_nospawn", 32'(obs_active), 0);

    // Fill the pool, confirm no fifth spawn, then force a retirement at pos 2.
    cycle(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 121; k++) cycle(0, 0, 1, 0, 8'h00, 0);
    check("pool_full", 32'(obs_active), 32'hF);
    guard = 0;
    while (m_pos[0] != 2 && guard < 200) begin
      cycle(0, 0, 1, 0, 8'h00, 0);
      guard++;
    end
    check("reach_pos2", 32'(obs_pos[7:0]), 2);
    cycle(0, 0, 1, 0, 8'h00, 3);
    check("retire_passed", 32'(passed_pulse), 1);
    check("retire_nospawn", 32'(spawn_pulse), 0);
    check("retire_slot0", 32'(obs_active[0]), 0);
    cycle(0, 0, 1, 0, 8'h00, 3);
    check("reuse_next_tick", 32'(obs_active[0]), 1);

    // Type folding.
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 8'h07, 0);
    check("type_fold7", 32'(obs_type[2:0]), 1);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 8'h05, 0);
    check("type_5", 32'(obs_type[2:0]), 5);

    // Reset mid-run beats start and tick.
    for (int k = 0; k < 60; k++) cycle(0, 0, 1, 0, 8'h00, 2);
    cycle(1, 1, 1, 0, 8'h00, 2);
    check("rst_active", 32'(obs_active), 0);
    check("rst_pos0", 32'(obs_pos[7:0]), 159);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 199) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) != 0) ? $urandom_range(0, 63) : $urandom_range(0, 255),
            $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/obstacle_pool.md
OBSTACLE_POOL -- requirements
Module: obstacle_pool

Interface
REQ-001 SHALL have parameter NUM_OBS, default 4, number of obstacle slots, legal 2..8.
REQ-002 SHALL have parameter CONV, default 2, coordinate shift; position width PW = 10-CONV.
REQ-003 SHALL have parameter SPAWN_X, default 159, spawn x coordinate, < 2^PW.
REQ-004 SHALL have parameter MIN_GAP, default 40, minimum spawn spacing in pixels, legal 5..SPAWN_X.
REQ-005 SHALL have parameter SPAWN_THRESH, default 8, 5-bit spawn probability threshold.
REQ-006 SHALL have port clk  in  1  system clock; all logic on the rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port game_tick  in  1  one-cycle movement strobe.
REQ-009 SHALL have port game_start  in  1  one-cycle new-game strobe.
REQ-010 SHALL have port game_frozen  in  1  high = movement and spawning halted.
REQ-011 SHALL have port rng  in  8  free-running random value.
REQ-012 SHALL have port speed  in  2  base step; step = speed+1 pixels per tick.
REQ-013 SHALL have port obs_pos  out  NUM_OBS*PW  packed slot x positions, slot i at [i*PW +: PW].
REQ-014 SHALL have port obs_type  out  NUM_OBS*3  packed slot types, slot i at [i*3 +: 3].
REQ-015 SHALL have port obs_active  out  NUM_OBS  slot-occupied flags.
REQ-016 SHALL have port spawn_pulse  out  1  one-cycle strobe, obstacle spawned.
REQ-017 SHALL have port passed_pulse  out  1  one-cycle strobe, obstacle retired off-screen left.

Function
REQ-018 All outputs SHALL be registered; updates occur only on the edge where game_tick=1 (or game_start/rst), pulses last exactly one cycle.
REQ-019 Inactive slot SHALL present pos=SPAWN_X, type=0, active=0.
REQ-020 On tick with game_frozen=0, each active slot with pos >= step SHALL decrement pos by step.
REQ-021 Active slot with pos < step SHALL retire: active=0, pos=SPAWN_X, type=0, passed_pulse=1; MIN_GAP>4 guarantees at most one retirement per tick.
REQ-022 Spawn SHALL occur in the same tick if: a slot free before this tick exists, rng[7:3] < SPAWN_THRESH, and the last-spawned slot is inactive or its post-move pos <= SPAWN_X-MIN_GAP.
REQ-023 Spawn SHALL fill the lowest-index free slot: pos=SPAWN_X, active=1, type=rng[2:0] if <=5 else rng[2:0]-6; spawn_pulse=1; slot index recorded as last-spawned.
REQ-024 Slot freed by retirement SHALL NOT be reused until the next tick; pool full -> no spawn, no pulse, no error.
REQ-025 game_frozen=1 SHALL ignore ticks: positions, types, flags hold, no pulses.
REQ-026 game_start SHALL take priority over game_tick and frozen: all slots inactive, last-spawned cleared, pulses 0, ramp cleared.
REQ-027 Two slots SHALL never both hold pos=SPAWN_X while active.

Reset
REQ-028 rst=1 SHALL force state identical to game_start, overriding all inputs, including mid-movement; outputs valid the cycle after release.
REQ-029 rst SHALL take priority over game_start.

Configuration
REQ-030 Macro OBSTACLE_POOL_SPEED_RAMP_EN defined: 2-bit ramp counter increments every 16 spawns, saturates at 3; step = min(4, speed+1+ramp); cleared by rst/game_start.
REQ-031 Macro undefined: no ramp logic, step = speed+1 exactly.

Verification (NUM_OBS=4, CONV=2, SPAWN_X=159, MIN_GAP=40, macro undefined)
REQ-032 rst then game_start, rng=8'h00, speed=0, one tick -> slot0 active pos=159 type=0, spawn_pulse one cycle; next tick slot0 pos=158, no spawn (gap).
REQ-033 rng=8'h00, speed=3, 10 ticks -> slot0 pos=123, slot1 spawned at tick 11 when slot0 reaches 119; rng=8'hFF never spawns.
REQ-034 Force all 4 slots active, keep rng=8'h00 -> no fifth spawn, spawn_pulse stays 0; slot at pos=2 speed=3 next tick retires, passed_pulse=1, same tick no spawn into it.
REQ-035 game_frozen=1 for 20 ticks with 2 active slots -> obs_pos, obs_type, obs_active unchanged, no pulses; game_start coincident with tick -> all cleared.
REQ-036 rng[2:0]=7 at spawn -> type=1; rng[2:0]=5 -> type=5; rst asserted mid-run -> all obs_active=0, pos=159 next cycle.
